// File: rtl/divider_result_corrector.sv
// divider_result_corrector
//   Post-processing stage for the non-restoring signed divider. Takes the raw
//   quotient/remainder, whose signs are not normalised, together with the
//   original operands, and produces canonical results satisfying
//   N = Q*D + R with |R| < |D|.
//   Default build: truncating division, R is zero or has the sign of N.
//   Optional macro DIVCORR_FLOOR_EN: floored division, R is zero or has the sign of D.
//   The divide-by-zero output is the same in both builds.
//
// Ports
//   CLK, SRST           clock, synchronous active-high reset
//   CE                  clock enable; all state holds while low
//   in_valid, in_ready  input handshake (one transaction in flight, no buffering)
//   QUOT_IN, REM_IN     raw divider quotient / remainder
//   NUM_IN, DEN_IN      original numerator / denominator
//   ERR_IN              divider divide-by-zero flag
//   out_valid, out_ready output handshake
//   QUOT_OUT, REM_OUT   corrected quotient / remainder (held while stalled)
//   err_out             divide-by-zero or correction-limit fault
module divider_result_corrector #(
  parameter int WORD_WIDTH = 10
) (
  input  logic                  CLK,
  input  logic                  SRST,
  input  logic                  CE,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] QUOT_IN,
  input  logic [WORD_WIDTH-1:0] REM_IN,
  input  logic [WORD_WIDTH-1:0] NUM_IN,
  input  logic [WORD_WIDTH-1:0] DEN_IN,
  input  logic                  ERR_IN,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] QUOT_OUT,
  output logic [WORD_WIDTH-1:0] REM_OUT,
  output logic                  err_out
);

  localparam int IW = WORD_WIDTH + 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_ADJ, S_OUT} state_t;

  state_t                state_q;
  logic [IW-1:0]         q_q, r_q, d_q;
  logic [1:0]            adj_cnt_q;
  logic                  fix_up_q, fix_dn_q;
  logic                  in_ready_q, out_valid_q, err_q;
  logic [WORD_WIDTH-1:0] quot_q, rem_q;
  logic                  fix_up_d, fix_dn_d;
  logic                  r_nz, r_neg, d_neg;
`ifndef DIVCORR_FLOOR_EN
  // Only the numerator's sign takes part in the correction decision.
  logic                  n_neg_q;
`endif

  function automatic logic [IW-1:0] sext(input logic [WORD_WIDTH-1:0] x);
    return {x[WORD_WIDTH-1], x};
  endfunction

  always_comb begin
    r_nz  = (r_q != '0);
    r_neg = r_q[IW-1];
    d_neg = d_q[IW-1];
`ifdef DIVCORR_FLOOR_EN
    fix_up_d = (r_q == d_q);
    fix_dn_d = r_nz && (r_neg != d_neg);
`else
    fix_up_d = (r_nz && (r_neg != n_neg_q) && (r_neg == d_neg)) || (r_q == d_q);
    fix_dn_d = (r_nz && (r_neg != n_neg_q) && (r_neg != d_neg)) || (r_q == (-d_q));
`endif
  end

  always_ff @(posedge CLK) begin
    if (SRST) begin
      state_q     <= S_IDLE;
      q_q         <= '0;
      r_q         <= '0;
      d_q         <= '0;
`ifndef DIVCORR_FLOOR_EN
      n_neg_q     <= 1'b0;
`endif
      adj_cnt_q   <= '0;
      fix_up_q    <= 1'b0;
      fix_dn_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      quot_q      <= '0;
      rem_q       <= '0;
    end else if (CE) begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            in_ready_q <= 1'b0;
            adj_cnt_q  <= '0;
            d_q        <= sext(DEN_IN);
`ifndef DIVCORR_FLOOR_EN
            n_neg_q    <= NUM_IN[WORD_WIDTH-1];
`endif
            if (ERR_IN) begin
              q_q         <= '1;
              r_q         <= sext(NUM_IN);
              quot_q      <= '1;
              rem_q       <= NUM_IN;
              err_q       <= 1'b1;
              out_valid_q <= 1'b1;
              state_q     <= S_OUT;
            end else begin
              q_q     <= sext(QUOT_IN);
              r_q     <= sext(REM_IN);
              err_q   <= 1'b0;
              state_q <= S_CHECK;
            end
          end
        end
        S_CHECK: begin
          fix_up_q <= fix_up_d;
          fix_dn_q <= fix_dn_d;
          if (!fix_up_d && !fix_dn_d) begin
            quot_q      <= q_q[WORD_WIDTH-1:0];
            rem_q       <= r_q[WORD_WIDTH-1:0];
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else if (adj_cnt_q == 2'd2) begin
            // A consistent raw result never needs a third adjust.
            quot_q      <= q_q[WORD_WIDTH-1:0];
            rem_q       <= r_q[WORD_WIDTH-1:0];
            err_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= S_OUT;
          end else begin
            state_q <= S_ADJ;
          end
        end
        S_ADJ: begin
          if (fix_up_q) begin
            q_q <= q_q + 1'b1;
            r_q <= r_q - d_q;
          end else if (fix_dn_q) begin
            q_q <= q_q - 1'b1;
            r_q <= r_q + d_q;
          end
          adj_cnt_q <= adj_cnt_q + 2'd1;
          state_q   <= S_CHECK;
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign QUOT_OUT  = quot_q;
  assign REM_OUT   = rem_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_divider_result_corrector.sv
module tb_divider_result_corrector;

  logic       CLK = 1'b0;
  logic       SRST = 1'b1;
  logic       CE = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] QUOT_IN = '0;
  logic [9:0] REM_IN = '0;
  logic [9:0] NUM_IN = '0;
  logic [9:0] DEN_IN = '0;
  logic       ERR_IN = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [9:0] QUOT_OUT;
  logic [9:0] REM_OUT;
  logic       err_out;

  int checks = 0;
  int errors = 0;

  divider_result_corrector #(.WORD_WIDTH(10)) dut (
    .CLK(CLK), .SRST(SRST), .CE(CE),
    .in_valid(in_valid), .in_ready(in_ready),
    .QUOT_IN(QUOT_IN), .REM_IN(REM_IN), .NUM_IN(NUM_IN), .DEN_IN(DEN_IN),
    .ERR_IN(ERR_IN),
    .out_valid(out_valid), .out_ready(out_ready),
    .QUOT_OUT(QUOT_OUT), .REM_OUT(REM_OUT), .err_out(err_out)
  );

  always #5 CLK = ~CLK;

  // Presents one transaction and returns the number of rising edges from
  // the accept edge (inclusive) until out_valid is seen; 99 if never accepted.
  task automatic do_txn(input logic [9:0] q, input logic [9:0] r, input logic [9:0] n,
                        input logic [9:0] d, input logic e, output int lat);
    int guard;
    @(negedge CLK);
    QUOT_IN = q; REM_IN = r; NUM_IN = n; DEN_IN = d; ERR_IN = e;
    in_valid = 1'b1;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    if (guard == 20) begin
      in_valid = 1'b0;
      lat = 99;
      return;
    end
    @(posedge CLK);
    @(negedge CLK);
    in_valid = 1'b0;
    ERR_IN = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
  endtask

  task automatic consume();
    @(negedge CLK);
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    SRST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if ({out_valid, in_ready, err_out} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got v/r/e=%b%b%b want 000", out_valid, in_ready, err_out);
    end
    checks++;
    if ({QUOT_OUT, REM_OUT} !== 20'h0) begin
      errors++;
      $display("FAIL reset_data got Q=%h R=%h want 0 0", QUOT_OUT, REM_OUT);
    end
    SRST = 1'b0;
    @(negedge CLK);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready_rise got %b want 1", in_ready);
    end
  endtask

  task automatic test_correct(input string name, input logic [9:0] q, input logic [9:0] r,
                              input logic [9:0] n, input logic [9:0] d,
                              input logic [9:0] eq, input logic [9:0] er, input logic ee,
                              input int elat);
    int lat;
    do_txn(q, r, n, d, 1'b0, lat);
    checks++;
    if (lat !== elat) begin
      errors++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, elat);
    end
    checks++;
    if ({QUOT_OUT, REM_OUT, err_out} !== {eq, er, ee}) begin
      errors++;
      $display("FAIL %s_result got Q=%h R=%h e=%b want Q=%h R=%h e=%b",
               name, QUOT_OUT, REM_OUT, err_out, eq, er, ee);
    end
    consume();
  endtask

  task automatic test_div0();
    int lat;
    do_txn(10'd0, 10'd0, 10'd5, 10'd0, 1'b1, lat);
    checks++;
    if (lat !== 1) begin
      errors++;
      $display("FAIL div0_latency got %0d want 1", lat);
    end
    checks++;
    if ({QUOT_OUT, REM_OUT, err_out} !== {10'h3FF, 10'd5, 1'b1}) begin
      errors++;
      $display("FAIL div0_result got Q=%h R=%h e=%b want Q=3ff R=005 e=1", QUOT_OUT, REM_OUT, err_out);
    end
    consume();
  endtask

  task automatic test_backpressure();
    int lat;
    do_txn(10'd4, 10'h3FF, 10'd7, 10'd2, 1'b0, lat);
    // A second request waits while the first result is stalled.
    QUOT_IN = 10'd2; REM_IN = 10'd0; NUM_IN = 10'd6; DEN_IN = 10'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if ({out_valid, in_ready, QUOT_OUT, REM_OUT} !== {1'b1, 1'b0, 10'd3, 10'd1}) begin
        errors++;
        $display("FAIL stall_hold got v=%b rdy=%b Q=%h R=%h want v=1 rdy=0 Q=003 R=001",
                 out_valid, in_ready, QUOT_OUT, REM_OUT);
      end
    end
    out_ready = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL stall_release got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready);
    end
    @(negedge CLK);
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge CLK);
      lat++;
    end
    checks++;
    if ({lat, QUOT_OUT, REM_OUT} !== {32'd2, 10'd2, 10'd0}) begin
      errors++;
      $display("FAIL stall_next got lat=%0d Q=%h R=%h want lat=2 Q=002 R=000", lat, QUOT_OUT, REM_OUT);
    end
    consume();
  endtask

  task automatic test_ce();
    int lat;
    do_txn(10'd2, 10'd0, 10'd6, 10'd3, 1'b0, lat);
    CE = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge CLK);
    checks++;
    if ({out_valid, in_ready, QUOT_OUT} !== {1'b1, 1'b0, 10'd2}) begin
      errors++;
      $display("FAIL ce_freeze got v=%b rdy=%b Q=%h want v=1 rdy=0 Q=002", out_valid, in_ready, QUOT_OUT);
    end
    CE = 1'b1;
    @(negedge CLK);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL ce_resume got v=%b want 0", out_valid);
    end
  endtask

  task automatic test_srst_mid();
    @(negedge CLK);
    QUOT_IN = 10'd4; REM_IN = 10'h3FF; NUM_IN = 10'd7; DEN_IN = 10'd2; in_valid = 1'b1;
    @(posedge CLK); // accept -> S_CHECK
    @(negedge CLK);
    in_valid = 1'b0;
    @(posedge CLK); // -> S_ADJ
    @(negedge CLK);
    SRST = 1'b1;
    @(negedge CLK);
    SRST = 1'b0;
    checks++;
    if ({out_valid, in_ready, err_out, QUOT_OUT, REM_OUT} !== 23'h0) begin
      errors++;
      $display("FAIL srst_mid got v=%b rdy=%b e=%b Q=%h R=%h want all 0",
               out_valid, in_ready, err_out, QUOT_OUT, REM_OUT);
    end
    test_correct("srst_resume", 10'd1, 10'd3, 10'd6, 10'd3, 10'd2, 10'd0, 1'b0, 4);
  endtask

  initial begin
    test_reset();
    test_correct("v1_fixdn", 10'd4, 10'h3FF, 10'd7, 10'd2, 10'd3, 10'd1, 1'b0, 4);
`ifdef DIVCORR_FLOOR_EN
    test_correct("v2_negnum", 10'h3FC, 10'd1, 10'h3F9, 10'd2, 10'h3FC, 10'd1, 1'b0, 2);
`else
    test_correct("v2_negnum", 10'h3FC, 10'd1, 10'h3F9, 10'd2, 10'h3FD, 10'h3FF, 1'b0, 4);
`endif
    test_correct("v3_req_d", 10'd1, 10'd3, 10'd6, 10'd3, 10'd2, 10'd0, 1'b0, 4);
    test_correct("v3_clean", 10'd2, 10'd0, 10'd6, 10'd3, 10'd2, 10'd0, 1'b0, 2);
    // MIN / -1: raw 511 rem -1 corrects to +512, which wraps to MIN.
    test_correct("min_by_m1", 10'd511, 10'h3FF, 10'h200, 10'h3FF, 10'h200, 10'd0, 1'b0, 4);
    // Zero denominator without ERR_IN never converges: two adjusts then fault.
    test_correct("limit", 10'd5, 10'd0, 10'd0, 10'd0, 10'd7, 10'd0, 1'b1, 6);
    test_div0();
    test_backpressure();
    test_ce();
    test_srst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
